// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Covers the NOP bubble, fetch FSM encoding and prefetch entry layout.
package if_stage_pkg;

    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Small circular prefetch buffer of {pc, instr} entries.
// The head is readable combinationally so a pop lands in IF/ID the same cycle.
module if_prefetch_fifo
    import if_stage_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_entry_t     wdata_i,
    output fetch_entry_t     rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the fetch PC, talks req/gnt/rvalid to program memory,
// buffers words in a prefetch FIFO and feeds decode one instruction per cycle.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        brj_i,
    input  logic [31:0] brj_pc_i,
    input  logic        stall_i,
    input  logic        stall_general_i,
    output logic [31:0] d_instruction_o,
    output logic [31:0] d_pc_o,
    output logic [31:0] d_pc4_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    if_state_e    state_q;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  req_pc_q;
    logic         discard_q;
    logic [31:0]  d_instr_q, d_instr_d;
    logic [31:0]  d_pc_q, d_pc_d;
    logic [31:0]  d_pc4_q, d_pc4_d;

    logic         redirect;
    logic         pop_ok;
    logic         rvalid_ok;
    logic         bypass;
    logic         granted;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_empty;
    logic         room;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   count_after;
    fetch_entry_t fifo_head;
    fetch_entry_t fifo_wdata;
    logic [31:0]  brj_target;

    assign brj_target = word_align(brj_pc_i);
    assign redirect   = brj_i && !stall_general_i;
    assign pop_ok     = !stall_general_i && !brj_i && !stall_i;
    assign rvalid_ok  = (state_q == IF_WAIT) && instr_rvalid_i && !discard_q;
    assign bypass     = rvalid_ok && fifo_empty && pop_ok;
    assign fifo_push  = rvalid_ok && !redirect && !bypass;
    assign fifo_pop   = pop_ok && !fifo_empty;

    // A redirect withdraws a pending request combinationally so no stale grant can occur.
    assign instr_req_o  = (state_q == IF_REQ) && !redirect;
    assign instr_addr_o = fetch_pc_q;
    assign granted      = instr_req_o && instr_gnt_i;

    assign count_after = redirect ? '0
                       : {1'b0, fifo_count} + (CNT_W+1)'(fifo_push) - (CNT_W+1)'(fifo_pop);
    assign room        = (count_after < (CNT_W+1)'(FIFO_DEPTH));

    assign fifo_wdata.pc    = req_pc_q;
    assign fifo_wdata.instr = instr_rdata_i;

    if_prefetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (redirect),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IF_IDLE;
            fetch_pc_q <= BOOT_ADDR;
            req_pc_q   <= BOOT_ADDR;
            discard_q  <= 1'b0;
        end else begin
            if (redirect) begin
                fetch_pc_q <= brj_target;
            end else if (granted) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            if (granted) begin
                req_pc_q <= fetch_pc_q;
            end
            unique case (state_q)
                IF_IDLE: begin
                    if (room) state_q <= IF_REQ;
                end
                IF_REQ: begin
                    if (redirect)         state_q <= IF_IDLE;
                    else if (instr_gnt_i) state_q <= IF_WAIT;
                end
                IF_WAIT: begin
                    if (instr_rvalid_i) begin
                        discard_q <= 1'b0;
                        state_q   <= room ? IF_REQ : IF_IDLE;
                    end else if (redirect) begin
                        // Response for the old path is still in flight; drop it on arrival.
                        discard_q <= 1'b1;
                    end
                end
                default: state_q <= IF_IDLE;
            endcase
        end
    end

    always_comb begin
        d_instr_d = d_instr_q;
        d_pc_d    = d_pc_q;
        d_pc4_d   = d_pc4_q;
        if (!stall_general_i) begin
            if (brj_i) begin
                d_instr_d = NOP_INSTR;
                d_pc_d    = brj_target - 32'd4;
                d_pc4_d   = brj_target;
            end else if (!stall_i) begin
                if (!fifo_empty) begin
                    d_instr_d = fifo_head.instr;
                    d_pc_d    = fifo_head.pc;
                    d_pc4_d   = fifo_head.pc + 32'd4;
                end else if (bypass) begin
                    d_instr_d = instr_rdata_i;
                    d_pc_d    = req_pc_q;
                    d_pc4_d   = req_pc_q + 32'd4;
                end else begin
                    d_instr_d = NOP_INSTR;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_instr_q <= NOP_INSTR;
            d_pc_q    <= BOOT_ADDR;
            d_pc4_q   <= BOOT_ADDR + 32'd4;
        end else begin
            d_instr_q <= d_instr_d;
            d_pc_q    <= d_pc_d;
            d_pc4_q   <= d_pc4_d;
        end
    end

    assign d_instruction_o = d_instr_q;
    assign d_pc_o          = d_pc_q;
    assign d_pc4_o         = d_pc4_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory handshake is driven cycle by cycle by each scenario task.
// Expected IF/ID contents are hand-derived per cycle.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        brj_i = 1'b0;
    logic [31:0] brj_pc_i = '0;
    logic        stall_i = 1'b0;
    logic        stall_general_i = 1'b0;
    logic [31:0] d_instruction_o;
    logic [31:0] d_pc_o;
    logic [31:0] d_pc4_o;

    int vectors = 0;
    int miscompares = 0;

    if_stage #(
        .BOOT_ADDR  (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .brj_i           (brj_i),
        .brj_pc_i        (brj_pc_i),
        .stall_i         (stall_i),
        .stall_general_i (stall_general_i),
        .d_instruction_o (d_instruction_o),
        .d_pc_o          (d_pc_o),
        .d_pc4_o         (d_pc4_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input logic g, input logic rv, input logic [31:0] rd);
        instr_gnt_i    = g;
        instr_rvalid_i = rv;
        instr_rdata_i  = rd;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_mem(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        vectors++;
        if ({d_instruction_o, d_pc_o, d_pc4_o} !== {NOP, 32'h0, 32'h4}) begin
            $display("FAIL reset_ifid: got %h/%h/%h want %h/00000000/00000004", d_instruction_o, d_pc_o, d_pc4_o, NOP);
            miscompares++;
        end
        vectors++;
        if (instr_req_o !== 1'b0) begin
            $display("FAIL reset_req: got %b want 0", instr_req_o);
            miscompares++;
        end
        rst = 1'b0;
        #1;
        $display("test_reset: done");
    endtask

    task automatic test_stream();
        logic [31:0] a;
        logic [95:0] want;
        set_mem(1'b0, 1'b0, 32'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            a = 32'(4 * k);
            set_mem(1'b1, 1'b0, 32'h0);
            vectors++;
            if ({instr_req_o, instr_addr_o} !== {1'b1, a}) begin
                $display("FAIL stream_req%0d: got %b/%h want 1/%h", k, instr_req_o, instr_addr_o, a);
                miscompares++;
            end
            tick();
            want = {NOP, (k == 0) ? 32'h0 : a - 32'd4, (k == 0) ? 32'h4 : a};
            vectors++;
            if ({d_instruction_o, d_pc_o, d_pc4_o} !== want) begin
                $display("FAIL stream_gap%0d: got %h/%h/%h want %h", k, d_instruction_o, d_pc_o, d_pc4_o, want);
                miscompares++;
            end
            set_mem(1'b0, 1'b1, a);
            tick();
            vectors++;
            if ({d_instruction_o, d_pc_o, d_pc4_o} !== {a, a, a + 32'd4}) begin
                $display("FAIL stream_word%0d: got %h/%h/%h want %h/%h/%h", k, d_instruction_o, d_pc_o, d_pc4_o, a, a, a + 32'd4);
                miscompares++;
            end
        end
        set_mem(1'b0, 1'b0, 32'h0);
        $display("test_stream: done");
    endtask

    task automatic test_no_grant();
        for (int k = 0; k < 10; k++) begin
            set_mem(1'b0, 1'b0, 32'h0);
            vectors++;
            if ({instr_req_o, instr_addr_o} !== {1'b1, 32'hC}) begin
                $display("FAIL nogrant_req%0d: got %b/%h want 1/0000000c", k, instr_req_o, instr_addr_o);
                miscompares++;
            end
            tick();
            vectors++;
            if (d_instruction_o !== NOP) begin
                $display("FAIL nogrant_nop%0d: got %h want %h", k, d_instruction_o, NOP);
                miscompares++;
            end
        end
        $display("test_no_grant: done");
    endtask

    task automatic test_redirect();
        set_mem(1'b1, 1'b0, 32'h0);
        tick();
        brj_i = 1'b1;
        brj_pc_i = 32'h100;
        set_mem(1'b0, 1'b0, 32'h0);
        tick();
        vectors++;
        if ({d_instruction_o, d_pc_o, d_pc4_o} !== {NOP, 32'hFC, 32'h100}) begin
            $display("FAIL redirect_nop: got %h/%h/%h want %h/000000fc/00000100", d_instruction_o, d_pc_o, d_pc4_o, NOP);
            miscompares++;
        end
        brj_i = 1'b0;
        set_mem(1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        vectors++;
        if ({d_instruction_o, d_pc_o} !== {NOP, 32'hFC}) begin
            $display("FAIL redirect_stale: got %h/%h want %h/000000fc", d_instruction_o, d_pc_o, NOP);
            miscompares++;
        end
        set_mem(1'b1, 1'b0, 32'h0);
        vectors++;
        if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h100}) begin
            $display("FAIL redirect_req: got %b/%h want 1/00000100", instr_req_o, instr_addr_o);
            miscompares++;
        end
        tick();
        set_mem(1'b0, 1'b1, 32'h100);
        tick();
        vectors++;
        if ({d_instruction_o, d_pc_o, d_pc4_o} !== {32'h100, 32'h100, 32'h104}) begin
            $display("FAIL redirect_target: got %h/%h/%h want 00000100/00000100/00000104", d_instruction_o, d_pc_o, d_pc4_o);
            miscompares++;
        end
        set_mem(1'b0, 1'b0, 32'h0);
        $display("test_redirect: done");
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        set_mem(1'b1, 1'b0, 32'h0);
        tick();
        set_mem(1'b0, 1'b1, 32'h104);
        tick();
        set_mem(1'b1, 1'b0, 32'h0);
        vectors++;
        if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h108}) begin
            $display("FAIL stall_req: got %b/%h want 1/00000108", instr_req_o, instr_addr_o);
            miscompares++;
        end
        tick();
        set_mem(1'b0, 1'b1, 32'h108);
        tick();
        set_mem(1'b0, 1'b0, 32'h0);
        vectors++;
        if (instr_req_o !== 1'b0) begin
            $display("FAIL stall_full_req: got %b want 0", instr_req_o);
            miscompares++;
        end
        tick();
        vectors++;
        if ({d_instruction_o, d_pc_o, d_pc4_o} !== {32'h100, 32'h100, 32'h104}) begin
            $display("FAIL stall_hold: got %h/%h/%h want 00000100/00000100/00000104", d_instruction_o, d_pc_o, d_pc4_o);
            miscompares++;
        end
        stall_i = 1'b0;
        #1;
        tick();
        vectors++;
        if ({d_instruction_o, d_pc_o, d_pc4_o} !== {32'h104, 32'h104, 32'h108}) begin
            $display("FAIL stall_pop1: got %h/%h/%h want 00000104/00000104/00000108", d_instruction_o, d_pc_o, d_pc4_o);
            miscompares++;
        end
        set_mem(1'b1, 1'b0, 32'h0);
        vectors++;
        if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h10C}) begin
            $display("FAIL stall_resume_req: got %b/%h want 1/0000010c", instr_req_o, instr_addr_o);
            miscompares++;
        end
        tick();
        vectors++;
        if ({d_instruction_o, d_pc_o, d_pc4_o} !== {32'h108, 32'h108, 32'h10C}) begin
            $display("FAIL stall_pop2: got %h/%h/%h want 00000108/00000108/0000010c", d_instruction_o, d_pc_o, d_pc4_o);
            miscompares++;
        end
        set_mem(1'b0, 1'b1, 32'h10C);
        tick();
        vectors++;
        if ({d_instruction_o, d_pc_o, d_pc4_o} !== {32'h10C, 32'h10C, 32'h110}) begin
            $display("FAIL stall_bypass: got %h/%h/%h want 0000010c/0000010c/00000110", d_instruction_o, d_pc_o, d_pc4_o);
            miscompares++;
        end
        set_mem(1'b0, 1'b0, 32'h0);
        $display("test_stall: done");
    endtask

    task automatic test_stall_general();
        stall_general_i = 1'b1;
        brj_i = 1'b1;
        brj_pc_i = 32'h203;
        set_mem(1'b1, 1'b0, 32'h0);
        vectors++;
        if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h110}) begin
            $display("FAIL sg_req: got %b/%h want 1/00000110", instr_req_o, instr_addr_o);
            miscompares++;
        end
        tick();
        vectors++;
        if ({d_instruction_o, d_pc_o, d_pc4_o} !== {32'h10C, 32'h10C, 32'h110}) begin
            $display("FAIL sg_freeze1: got %h/%h/%h want 0000010c/0000010c/00000110", d_instruction_o, d_pc_o, d_pc4_o);
            miscompares++;
        end
        set_mem(1'b0, 1'b1, 32'h110);
        tick();
        vectors++;
        if ({d_instruction_o, d_pc_o, d_pc4_o} !== {32'h10C, 32'h10C, 32'h110}) begin
            $display("FAIL sg_freeze2: got %h/%h/%h want 0000010c/0000010c/00000110", d_instruction_o, d_pc_o, d_pc4_o);
            miscompares++;
        end
        stall_general_i = 1'b0;
        set_mem(1'b0, 1'b0, 32'h0);
        vectors++;
        if (instr_req_o !== 1'b0) begin
            $display("FAIL sg_req_drop: got %b want 0", instr_req_o);
            miscompares++;
        end
        tick();
        vectors++;
        if ({d_instruction_o, d_pc_o, d_pc4_o} !== {NOP, 32'h1FC, 32'h200}) begin
            $display("FAIL sg_release_brj: got %h/%h/%h want %h/000001fc/00000200", d_instruction_o, d_pc_o, d_pc4_o, NOP);
            miscompares++;
        end
        brj_i = 1'b0;
        #1;
        tick();
        vectors++;
        if ({d_instruction_o, d_pc_o} !== {NOP, 32'h1FC}) begin
            $display("FAIL sg_flushed: got %h/%h want %h/000001fc", d_instruction_o, d_pc_o, NOP);
            miscompares++;
        end
        set_mem(1'b1, 1'b0, 32'h0);
        vectors++;
        if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h200}) begin
            $display("FAIL sg_target_req: got %b/%h want 1/00000200", instr_req_o, instr_addr_o);
            miscompares++;
        end
        tick();
        set_mem(1'b0, 1'b1, 32'h200);
        tick();
        vectors++;
        if ({d_instruction_o, d_pc_o, d_pc4_o} !== {32'h200, 32'h200, 32'h204}) begin
            $display("FAIL sg_target_word: got %h/%h/%h want 00000200/00000200/00000204", d_instruction_o, d_pc_o, d_pc4_o);
            miscompares++;
        end
        set_mem(1'b0, 1'b0, 32'h0);
        $display("test_stall_general: done");
    endtask

    task automatic test_reset_in_wait();
        set_mem(1'b1, 1'b0, 32'h0);
        tick();
        rst = 1'b1;
        set_mem(1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        set_mem(1'b0, 1'b1, 32'hBAD0_0BAD);
        vectors++;
        if (instr_req_o !== 1'b0) begin
            $display("FAIL rstwait_req: got %b want 0", instr_req_o);
            miscompares++;
        end
        tick();
        vectors++;
        if ({d_instruction_o, d_pc_o, d_pc4_o} !== {NOP, 32'h0, 32'h4}) begin
            $display("FAIL rstwait_ifid: got %h/%h/%h want %h/00000000/00000004", d_instruction_o, d_pc_o, d_pc4_o, NOP);
            miscompares++;
        end
        set_mem(1'b1, 1'b0, 32'h0);
        vectors++;
        if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h0}) begin
            $display("FAIL rstwait_boot_req: got %b/%h want 1/00000000", instr_req_o, instr_addr_o);
            miscompares++;
        end
        tick();
        set_mem(1'b0, 1'b1, 32'hCAFE_0000);
        tick();
        vectors++;
        if ({d_instruction_o, d_pc_o, d_pc4_o} !== {32'hCAFE_0000, 32'h0, 32'h4}) begin
            $display("FAIL rstwait_first: got %h/%h/%h want cafe0000/00000000/00000004", d_instruction_o, d_pc_o, d_pc4_o);
            miscompares++;
        end
        set_mem(1'b0, 1'b0, 32'h0);
        $display("test_reset_in_wait: done");
    endtask

    task automatic test_wrap();
        brj_i = 1'b1;
        brj_pc_i = 32'h0000_0002;
        set_mem(1'b0, 1'b0, 32'h0);
        tick();
        vectors++;
        if ({d_instruction_o, d_pc_o, d_pc4_o} !== {NOP, 32'hFFFF_FFFC, 32'h0}) begin
            $display("FAIL wrap_ifid: got %h/%h/%h want %h/fffffffc/00000000", d_instruction_o, d_pc_o, d_pc4_o, NOP);
            miscompares++;
        end
        brj_i = 1'b0;
        #1;
        tick();
        vectors++;
        if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h0}) begin
            $display("FAIL wrap_req: got %b/%h want 1/00000000", instr_req_o, instr_addr_o);
            miscompares++;
        end
        $display("test_wrap: done");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_no_grant();
        test_redirect();
        test_stall();
        test_stall_general();
        test_reset_in_wait();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
